stopwatch_run_control: RTL
==========================

Name: stopwatch_run_control

Overview:
Sequencing controller for the stopwatch timebase and display path.
- Consumes the 1 Hz tick strobe and the debounced start/pause and reset keys.
- Runs the IDLE/RUN/PAUSE control state machine.
- Holds the MM:SS count as four BCD digits, ready for the 7-segment decoders.
- Sits between the clock divider/debouncers and the HEX0..HEX3 drivers.

Parameters:
MAX_MINUTES, 59, highest minute value before wrap/saturate; legal 1..99
WRAP, 1, 1 = wrap to 00:00 and keep running at MAX_MINUTES:59; 0 = saturate and pause

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
tick_en  input  1  one-cycle strobe, 1 Hz, synchronous to clk
start_pause_n  input  1  debounced start/pause key level, active-low
reset_req_n  input  1  debounced reset key level, active-low
lap_n  input  1  debounced lap key level, active-low (LAP_EN builds only)
sec_ones  output  4  BCD seconds units, 0..9
sec_tens  output  4  BCD seconds tens, 0..5
min_ones  output  4  BCD minutes units, 0..9
min_tens  output  4  BCD minutes tens, 0..9
running  output  1  high while state = RUN
overflow  output  1  one-cycle pulse when count reaches/passes the limit

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, all digits 0, running 0, overflow 0, lap hold 0.
- Reset: key edge-detect registers load 1 (released).
- Key handling: each key level is registered once. A press is prev=1 and cur=0, which gives a one-cycle internal pulse.
- Holding a key produces exactly one press. Release produces nothing.
- States and transitions:
  - IDLE: count 00:00. sp press -> RUN.
  - RUN: sp press -> PAUSE.
  - PAUSE: sp press -> RUN.
  - Any state: reset press -> IDLE, count cleared on the same edge.
- Priority: reset press beats sp press in the same cycle.
- A tick in the same cycle as a reset press is discarded.
- A tick is counted only when the current (pre-edge) state is RUN. A tick coinciding with an sp press in RUN is counted and the state still goes to PAUSE.
- Ticks in IDLE/PAUSE are ignored.
- Increment (BCD ripple, all digits updated on one edge):
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into minutes.
  - min_ones 9->0 carries into min_tens.
- Limit reached when the count is MAX_MINUTES:59 and a tick arrives:
  - WRAP=1: count -> 00:00, overflow=1 for one cycle, stay RUN.
  - WRAP=0: count holds MAX_MINUTES:59, overflow=1 for one cycle, state -> PAUSE.
  - With WRAP=0, a later sp press -> RUN, and the next tick re-pulses overflow with no change to the count.
- Latency:
  - Digits change on the clk edge that samples tick_en.
  - running changes on the edge that samples the press pulse. Key fall to running change is 2 cycles (register stage plus edge detect).
- All outputs are registered. Digits never leave their BCD ranges.

Optional Feature:
LAP_STOPWATCH_EN
- Defined:
  - The lap_n port exists.
  - A lap press in RUN toggles lap hold. While held, the digit outputs freeze at the value present at the press edge, and the internal count keeps advancing.
  - A lap press in PAUSE releases the hold only. A lap press in IDLE is ignored.
  - A reset press clears the hold. running and overflow are never frozen.
  - A lap press coinciding with an sp or reset press is processed after them in the same cycle: a reset press clears the hold; a lap press with an sp press acts on the pre-edge state.
- Not defined: no lap_n port, no hold logic, and digit outputs always show the live count.

Test Plan:
- Reset, then 5 ticks with no key -> digits 00:00, running=0.
- sp press, then 75 ticks -> 01:15, running=1. sp press, then 10 ticks -> still 01:15, running=0.
- Preload to 00:59 in RUN, then 1 tick -> 01:00. Preload 09:59, then 1 tick -> 10:00.
- WRAP=1, MAX_MINUTES=59, at 59:59 tick -> 00:00, overflow pulse exactly 1 cycle, running=1. WRAP=0 -> holds 59:59, running=0.
- Reset press and tick in the same cycle at 02:30 -> 00:00, IDLE, no overflow. sp and reset together from IDLE -> stays IDLE.
- LAP_STOPWATCH_EN: lap press at 00:10, then 20 ticks -> outputs 00:10. Lap press again -> 00:30. rst_n pulse mid-run -> 00:00 asynchronously.

Source files
------------

// File: rtl/stopwatch_run_control_if.sv
// Key/tick inputs and BCD display outputs of the stopwatch run controller.
// The lap_n key exists only when LAP_STOPWATCH_EN is defined.
interface stopwatch_run_control_if;
    logic       tick_en;
    logic       start_pause_n;
    logic       reset_req_n;
`ifdef LAP_STOPWATCH_EN
    logic       lap_n;
`endif
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       overflow;

`ifdef LAP_STOPWATCH_EN
    modport master (output tick_en, start_pause_n, reset_req_n, lap_n,
                    input  sec_ones, sec_tens, min_ones, min_tens, running, overflow);
    modport slave  (input  tick_en, start_pause_n, reset_req_n, lap_n,
                    output sec_ones, sec_tens, min_ones, min_tens, running, overflow);
`else
    modport master (output tick_en, start_pause_n, reset_req_n,
                    input  sec_ones, sec_tens, min_ones, min_tens, running, overflow);
    modport slave  (input  tick_en, start_pause_n, reset_req_n,
                    output sec_ones, sec_tens, min_ones, min_tens, running, overflow);
`endif
endinterface

// File: rtl/stopwatch_run_control.sv
// IDLE/RUN/PAUSE stopwatch controller holding MM:SS as four BCD digits.
// Define LAP_STOPWATCH_EN to add the lap key and display-freeze hold.
module stopwatch_run_control #(
    parameter int MAX_MINUTES = 59,
    parameter bit WRAP        = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    stopwatch_run_control_if.slave sw
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_MO = 4'(MAX_MINUTES % 10);

    state_t     state_q, state_d;
    logic [3:0] so_q, st_q, mo_q, mt_q;
    logic [3:0] so_d, st_d, mo_d, mt_d;
    logic       ovf_q, ovf_d, run_q;
    logic       sp_cur, sp_prev, rs_cur, rs_prev;
    logic       sp_press, rs_press, tick_run, at_limit;

    // One register stage per key, then a falling-level detect against the previous sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_cur  <= 1'b1;
            sp_prev <= 1'b1;
            rs_cur  <= 1'b1;
            rs_prev <= 1'b1;
        end else begin
            sp_cur  <= sw.start_pause_n;
            sp_prev <= sp_cur;
            rs_cur  <= sw.reset_req_n;
            rs_prev <= rs_cur;
        end
    end

    assign sp_press = sp_prev & ~sp_cur;
    assign rs_press = rs_prev & ~rs_cur;
    assign tick_run = sw.tick_en && (state_q == RUN);
    assign at_limit = (mt_q == MAX_MT) && (mo_q == MAX_MO) && (st_q == 4'd5) && (so_q == 4'd9);

    always_comb begin
        state_d = state_q;
        so_d    = so_q;
        st_d    = st_q;
        mo_d    = mo_q;
        mt_d    = mt_q;
        ovf_d   = 1'b0;
        if (rs_press) begin
            state_d = IDLE;
            so_d    = 4'd0;
            st_d    = 4'd0;
            mo_d    = 4'd0;
            mt_d    = 4'd0;
        end else begin
            if (sp_press)
                state_d = (state_q == RUN) ? PAUSE : RUN;
            if (tick_run) begin
                if (at_limit) begin
                    ovf_d = 1'b1;
                    if (WRAP) begin
                        so_d = 4'd0;
                        st_d = 4'd0;
                        mo_d = 4'd0;
                        mt_d = 4'd0;
                    end else begin
                        state_d = PAUSE;
                    end
                end else if (so_q != 4'd9) begin
                    so_d = so_q + 4'd1;
                end else begin
                    so_d = 4'd0;
                    if (st_q != 4'd5) begin
                        st_d = st_q + 4'd1;
                    end else begin
                        st_d = 4'd0;
                        if (mo_q != 4'd9) begin
                            mo_d = mo_q + 4'd1;
                        end else begin
                            mo_d = 4'd0;
                            mt_d = mt_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            so_q    <= 4'd0;
            st_q    <= 4'd0;
            mo_q    <= 4'd0;
            mt_q    <= 4'd0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            so_q    <= so_d;
            st_q    <= st_d;
            mo_q    <= mo_d;
            mt_q    <= mt_d;
            ovf_q   <= ovf_d;
            run_q   <= (state_d == RUN);
        end
    end

    assign sw.running  = run_q;
    assign sw.overflow = ovf_q;

`ifdef LAP_STOPWATCH_EN
    logic        lp_cur, lp_prev, lp_press, hold_q, hold_d;
    logic [15:0] disp_q, disp_d;

    assign lp_press = lp_prev & ~lp_cur;

    // Lap acts on the pre-edge state after reset/sp have been resolved.
    always_comb begin
        hold_d = hold_q;
        if (rs_press)
            hold_d = 1'b0;
        else if (lp_press) begin
            case (state_q)
                RUN:     hold_d = ~hold_q;
                PAUSE:   hold_d = 1'b0;
                default: hold_d = hold_q;
            endcase
        end
        disp_d = hold_d ? disp_q : {mt_d, mo_d, st_d, so_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cur  <= 1'b1;
            lp_prev <= 1'b1;
            hold_q  <= 1'b0;
            disp_q  <= 16'd0;
        end else begin
            lp_cur  <= sw.lap_n;
            lp_prev <= lp_cur;
            hold_q  <= hold_d;
            disp_q  <= disp_d;
        end
    end

    assign {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} = disp_q;
`else
    assign sw.sec_ones = so_q;
    assign sw.sec_tens = st_q;
    assign sw.min_ones = mo_q;
    assign sw.min_tens = mt_q;
`endif
endmodule
